// File: rtl/eco_sweep_checker_if.sv
// Bundle of sweep control, stimulus, response and result signals between the
// sweep checker and its environment (circuit under test, golden model, host).
interface eco_sweep_checker_if #(
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [4:0]       a_out;
  logic [4:0]       b_out;
  logic [2:0]       y_dut;
  logic [2:0]       y_gold;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [10:0]      mismatch_cnt;
  logic             first_fail_valid;
  logic [9:0]       first_fail_vec;
  logic [2:0]       first_fail_y;

  // Environment side: issues control, supplies responses, observes results.
  modport master (
    output start, abort, y_dut, y_gold,
    input  a_out, b_out, busy, done, signature, mismatch_cnt,
           first_fail_valid, first_fail_vec, first_fail_y
  );

  // Checker side: drives the vectors and reports the compacted results.
  modport slave (
    input  start, abort, y_dut, y_gold,
    output a_out, b_out, busy, done, signature, mismatch_cnt,
           first_fail_valid, first_fail_vec, first_fail_y
  );
endinterface

// File: rtl/eco_sweep_checker.sv
// Exhaustive 5x5-bit stimulus sequencer with MISR response compaction and
// golden comparison (mismatch count plus first failing vector capture).
module eco_sweep_checker #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input logic                clk,
  input logic                rst,
  eco_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t           state_q, state_nxt;
  logic [9:0]       idx_q, idx_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [SIG_W-1:0] sig_q, sig_nxt;
  logic [SIG_W-1:0] sig_step;
  logic [10:0]      mcnt_q, mcnt_nxt;
  logic             ffv_q, ffv_nxt;
  logic [9:0]       ffvec_q, ffvec_nxt;
  logic [2:0]       ffy_q, ffy_nxt;
  logic             resp_mismatch;

  // Next-state and datapath decisions; the vector currently on a_out/b_out
  // (idx_q) is the one whose response is being captured this cycle.
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    busy_nxt      = busy_q;
    done_nxt      = done_q;
    sig_nxt       = sig_q;
    mcnt_nxt      = mcnt_q;
    ffv_nxt       = ffv_q;
    ffvec_nxt     = ffvec_q;
    ffy_nxt       = ffy_q;
    sig_step      = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-3){1'b0}}, bus.y_dut};
    resp_mismatch = (bus.y_dut != bus.y_gold);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
          sig_nxt   = SEED;
          mcnt_nxt  = '0;
          ffv_nxt   = 1'b0;
          ffvec_nxt = '0;
          ffy_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
        end else begin
          sig_nxt = sig_step;
          if (resp_mismatch) begin
            mcnt_nxt = mcnt_q + 11'd1;
            if (!ffv_q) begin
              ffv_nxt   = 1'b1;
              ffvec_nxt = idx_q;
              ffy_nxt   = bus.y_dut;
            end
          end
          if (idx_q == 10'd1023) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx_q + 10'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Vector index, status flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SEED;
      mcnt_q  <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      ffy_q   <= '0;
    end else begin
      idx_q   <= idx_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      sig_q   <= sig_nxt;
      mcnt_q  <= mcnt_nxt;
      ffv_q   <= ffv_nxt;
      ffvec_q <= ffvec_nxt;
      ffy_q   <= ffy_nxt;
    end
  end

  assign bus.a_out            = idx_q[4:0];
  assign bus.b_out            = idx_q[9:5];
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.signature        = sig_q;
  assign bus.mismatch_cnt     = mcnt_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.first_fail_y     = ffy_q;

endmodule

// File: tb/tb_eco_sweep_checker.sv
// Directed bench for eco_sweep_checker: a small adder-style circuit under test
// and a configurable golden source drive the response side of the interface.
module tb_eco_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   y_mode = 0;
  int   gold_mode = 0;
  int   n_edges;

  eco_sweep_checker_if #(.SIG_W(16)) bus ();

  eco_sweep_checker #(
    .SIG_W(16),
    .POLY (16'h1021),
    .SEED (16'hFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Circuit under test: y = (a + b) mod 8, or constant zero.
  function automatic logic [2:0] cut_y(input logic [9:0] v);
    logic [5:0] s;
    s = {1'b0, v[4:0]} + {1'b0, v[9:5]};
    return s[2:0];
  endfunction

  // Reference MISR over the first n vectors of a sweep.
  function automatic logic [15:0] model_sig(input int n, input int ymode);
    logic [15:0] s;
    logic [2:0]  y;
    logic [9:0]  v;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      v = 10'(i);
      y = (ymode == 1) ? cut_y(v) : 3'b000;
      s = ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {13'b0, y};
    end
    return s;
  endfunction

  // Response of the circuit under test.
  always_comb begin
    bus.y_dut = (y_mode == 1) ? cut_y({bus.b_out, bus.a_out}) : 3'b000;
  end

  // Golden response: equal, single planted fault at 0x155, or inverted.
  always_comb begin
    case (gold_mode)
      1:       bus.y_gold = ({bus.b_out, bus.a_out} == 10'h155) ? (bus.y_dut ^ 3'b100) : bus.y_dut;
      2:       bus.y_gold = ~bus.y_dut;
      default: bus.y_gold = bus.y_dut;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_sweep();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 1100) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    step(2);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0h want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0h want 0", bus.done); end
    total++; if (bus.signature !== 16'hFFFF) begin bad++; $display("[TB] FAIL reset_sig: got %h want ffff", bus.signature); end
    total++; if (bus.mismatch_cnt !== 11'd0) begin bad++; $display("[TB] FAIL reset_mcnt: got %0d want 0", bus.mismatch_cnt); end
    total++; if ({bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y} !== 14'd0) begin bad++; $display("[TB] FAIL reset_ff: got %h want 0", {bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y}); end
    total++; if ({bus.b_out, bus.a_out} !== 10'd0) begin bad++; $display("[TB] FAIL reset_vec: got %h want 0", {bus.b_out, bus.a_out}); end
    rst = 1'b0;
    step(1);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %0h want 0", bus.busy); end
    start_sweep();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy: got %0h want 1", bus.busy); end
    total++; if ({bus.b_out, bus.a_out} !== 10'd0) begin bad++; $display("[TB] FAIL start_vec: got %h want 0", {bus.b_out, bus.a_out}); end
    step(5);
    total++; if ({bus.b_out, bus.a_out} !== 10'd5) begin bad++; $display("[TB] FAIL step_vec: got %h want 5", {bus.b_out, bus.a_out}); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++; if ({bus.busy, bus.b_out, bus.a_out} !== 11'd0) begin bad++; $display("[TB] FAIL rst_sweep: got %h want 0", {bus.busy, bus.b_out, bus.a_out}); end
  endtask

  task automatic test_clean_sweep();
    y_mode = 0; gold_mode = 0;
    start_sweep();
    total++; if ({bus.b_out, bus.a_out} !== 10'd0) begin bad++; $display("[TB] FAIL clean_vec0: got %h want 0", {bus.b_out, bus.a_out}); end
    for (int k = 1; k < 1024; k++) begin
      step(1);
      total++;
      if ({bus.done, bus.b_out, bus.a_out} !== {1'b0, 10'(k)}) begin
        bad++; $display("[TB] FAIL clean_step: got %h want %h", {bus.done, bus.b_out, bus.a_out}, {1'b0, 10'(k)});
      end
    end
    step(1);
    total++; if ({bus.done, bus.busy} !== 2'b10) begin bad++; $display("[TB] FAIL clean_done: got %b want 10", {bus.done, bus.busy}); end
    total++; if (bus.mismatch_cnt !== 11'd0) begin bad++; $display("[TB] FAIL clean_mcnt: got %0d want 0", bus.mismatch_cnt); end
    total++; if (bus.first_fail_valid !== 1'b0) begin bad++; $display("[TB] FAIL clean_ffv: got %0h want 0", bus.first_fail_valid); end
    total++; if (bus.signature !== model_sig(1024, 0)) begin bad++; $display("[TB] FAIL clean_sig: got %h want %h", bus.signature, model_sig(1024, 0)); end
    total++; if ({bus.b_out, bus.a_out} !== 10'h3FF) begin bad++; $display("[TB] FAIL clean_hold: got %h want 3ff", {bus.b_out, bus.a_out}); end
    step(3);
    total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL done_held: got %0h want 1", bus.done); end
  endtask

  task automatic test_single_fault();
    y_mode = 1; gold_mode = 1;
    start_sweep();
    wait_done(n_edges);
    total++; if (n_edges !== 1024) begin bad++; $display("[TB] FAIL single_len: got %0d want 1024", n_edges); end
    total++; if (bus.mismatch_cnt !== 11'd1) begin bad++; $display("[TB] FAIL single_mcnt: got %0d want 1", bus.mismatch_cnt); end
    total++; if (bus.first_fail_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_ffv: got %0h want 1", bus.first_fail_valid); end
    total++; if (bus.first_fail_vec !== 10'h155) begin bad++; $display("[TB] FAIL single_vec: got %h want 155", bus.first_fail_vec); end
    total++; if (bus.first_fail_y !== 3'b111) begin bad++; $display("[TB] FAIL single_y: got %b want 111", bus.first_fail_y); end
    total++; if (bus.signature !== model_sig(1024, 1)) begin bad++; $display("[TB] FAIL single_sig: got %h want %h", bus.signature, model_sig(1024, 1)); end
  endtask

  task automatic test_all_fail();
    y_mode = 1; gold_mode = 2;
    start_sweep();
    wait_done(n_edges);
    total++; if (n_edges !== 1024) begin bad++; $display("[TB] FAIL allf_len: got %0d want 1024", n_edges); end
    total++; if (bus.mismatch_cnt !== 11'd1024) begin bad++; $display("[TB] FAIL allf_mcnt: got %0d want 1024", bus.mismatch_cnt); end
    total++; if ({bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y} !== {1'b1, 10'h000, 3'b000}) begin bad++; $display("[TB] FAIL allf_ff: got %h want 2000", {bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y}); end
  endtask

  task automatic test_control();
    y_mode = 1; gold_mode = 0;
    start_sweep();
    step(299);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    total++; if ({bus.busy, bus.b_out, bus.a_out} !== {1'b1, 10'd300}) begin bad++; $display("[TB] FAIL ctl_start_ign: got %h want %h", {bus.busy, bus.b_out, bus.a_out}, {1'b1, 10'd300}); end
    step(723);
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL ctl_early: got %0h want 0", bus.done); end
    step(1);
    total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL ctl_done: got %0h want 1", bus.done); end
    total++; if (bus.signature !== model_sig(1024, 1)) begin bad++; $display("[TB] FAIL ctl_sig: got %h want %h", bus.signature, model_sig(1024, 1)); end
    // abort with a simultaneous start at cycle 500
    gold_mode = 2;
    start_sweep();
    step(499);
    bus.start = 1'b1; bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("[TB] FAIL abort_flags: got %b want 00", {bus.busy, bus.done}); end
    total++; if (bus.mismatch_cnt !== 11'd499) begin bad++; $display("[TB] FAIL abort_mcnt: got %0d want 499", bus.mismatch_cnt); end
    total++; if ({bus.first_fail_valid, bus.first_fail_vec} !== 11'h400) begin bad++; $display("[TB] FAIL abort_ff: got %h want 400", {bus.first_fail_valid, bus.first_fail_vec}); end
    total++; if (bus.signature !== model_sig(499, 1)) begin bad++; $display("[TB] FAIL abort_sig: got %h want %h", bus.signature, model_sig(499, 1)); end
    bus.abort = 1'b1;
    step(3);
    bus.abort = 1'b0;
    total++; if ({bus.busy, bus.mismatch_cnt} !== {1'b0, 11'd499}) begin bad++; $display("[TB] FAIL idle_frozen: got %h want %h", {bus.busy, bus.mismatch_cnt}, {1'b0, 11'd499}); end
    gold_mode = 0;
    start_sweep();
    total++; if ({bus.first_fail_valid, bus.mismatch_cnt} !== 12'd0) begin bad++; $display("[TB] FAIL restart_clear: got %h want 0", {bus.first_fail_valid, bus.mismatch_cnt}); end
    total++; if (bus.signature !== 16'hFFFF) begin bad++; $display("[TB] FAIL restart_seed: got %h want ffff", bus.signature); end
    wait_done(n_edges);
    total++; if (n_edges !== 1024) begin bad++; $display("[TB] FAIL restart_len: got %0d want 1024", n_edges); end
    total++; if (bus.mismatch_cnt !== 11'd0) begin bad++; $display("[TB] FAIL restart_mcnt: got %0d want 0", bus.mismatch_cnt); end
    total++; if (bus.signature !== model_sig(1024, 1)) begin bad++; $display("[TB] FAIL restart_sig: got %h want %h", bus.signature, model_sig(1024, 1)); end
  endtask

  task automatic test_reset_mid();
    y_mode = 1; gold_mode = 2;
    start_sweep();
    step(699);
    rst = 1'b1;
    step(1);
    total++; if ({bus.busy, bus.done, bus.b_out, bus.a_out} !== 12'd0) begin bad++; $display("[TB] FAIL mid_ctl: got %h want 0", {bus.busy, bus.done, bus.b_out, bus.a_out}); end
    total++; if ({bus.signature, bus.mismatch_cnt} !== {16'hFFFF, 11'd0}) begin bad++; $display("[TB] FAIL mid_res: got %h want %h", {bus.signature, bus.mismatch_cnt}, {16'hFFFF, 11'd0}); end
    total++; if ({bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y} !== 14'd0) begin bad++; $display("[TB] FAIL mid_ff: got %h want 0", {bus.first_fail_valid, bus.first_fail_vec, bus.first_fail_y}); end
    rst = 1'b0;
    gold_mode = 1;
    start_sweep();
    wait_done(n_edges);
    total++; if (n_edges !== 1024) begin bad++; $display("[TB] FAIL mid_len: got %0d want 1024", n_edges); end
    total++; if ({bus.mismatch_cnt, bus.first_fail_vec, bus.first_fail_y} !== {11'd1, 10'h155, 3'b111}) begin bad++; $display("[TB] FAIL mid_result: got %h want %h", {bus.mismatch_cnt, bus.first_fail_vec, bus.first_fail_y}, {11'd1, 10'h155, 3'b111}); end
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_all_fail();
    test_control();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eco_sweep_checker.md
# eco_sweep_checker

Exhaustive stimulus sequencer and response compactor for the 5-bit × 5-bit → 3-bit patched-netlist test circuits. It drives every {B, A} combination into the combinational circuit under test, one vector per clock. It samples the 3-bit Y response one cycle later and folds it into a 16-bit MISR signature. It also compares the response against a golden (pre-ECO or reference-model) Y and records the mismatch count and the first failing vector.

## Interface
- SIG_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial (x^16+x^12+x^5+1).
- SEED, 16'hFFFF: signature value loaded at sweep start and reset.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; honoured only in IDLE or DONE
- abort  input  1  terminate sweep, return to IDLE
- a_out  output  5  A operand to circuit under test (registered)
- b_out  output  5  B operand to circuit under test (registered)
- y_dut  input  3  Y from circuit under test (combinational from a_out/b_out)
- y_gold  input  3  expected Y for the same vector
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next start or rst
- signature  output  SIG_W  MISR result
- mismatch_cnt  output  11  number of vectors with y_dut != y_gold (0..1024)
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_vec  output  10  {b,a} of first mismatching vector
- first_fail_y  output  3  y_dut captured at first mismatch

## Operation
- FSM states: IDLE, SWEEP, DONE.
- Vector index idx is 10 bits. The driven vector is a_out = idx[4:0] and b_out = idx[9:5]. Order is 0..1023 ascending.
- IDLE/DONE + start:
  - Next state is SWEEP.
  - idx ← 0 and a_out/b_out ← 0.
  - signature ← SEED, mismatch_cnt ← 0, first_fail_* ← 0.
  - busy ← 1, done ← 0.
  - cap_valid ← 1.
- SWEEP, each edge with cap_valid=1:
  - Capture the response to the currently driven vector (cap_idx = the vector on a_out/b_out).
  - Signature update: sig ← ({sig[14:0],1'b0} ^ (sig[15] ? POLY : 0)) ^ {13'b0, y_dut}.
  - If y_dut != y_gold: mismatch_cnt increments. If first_fail_valid=0, then first_fail_vec ← cap_idx, first_fail_y ← y_dut, first_fail_valid ← 1.
  - If cap_idx < 1023: drive idx+1.
  - If cap_idx = 1023: go to DONE with busy ← 0 and done ← 1. a_out/b_out hold 1023.
- abort in SWEEP: go to IDLE with busy ← 0 and done stays 0. signature, mismatch_cnt and first_fail_* freeze at their last values. The capture on the abort edge is discarded.
- abort in IDLE/DONE: ignored. start is ignored in SWEEP.
- Simultaneous start and abort: abort wins in SWEEP. start wins in IDLE/DONE.
- mismatch_cnt cannot overflow: the maximum is 1024, which fits in 11 bits.

## Timing
- Reset values:
  - State IDLE; a_out = b_out = 0.
  - busy = 0, done = 0.
  - signature = SEED, mismatch_cnt = 0.
  - first_fail_valid = 0, first_fail_vec = 0, first_fail_y = 0.
- rst mid-sweep: all of the above apply on the same edge. No partial result survives.
- Edge E0 (start sampled): vector 0 is driven.
- Edge Ek, k=1..1023: captures vector k-1 and drives vector k.
- Edge E1024: captures vector 1023 and raises done.
- busy is high for exactly 1024 cycles. Edge E0 to done is 1024 cycles.
- y_dut and y_gold must settle within one clock of a_out/b_out changing. The circuit under test is purely combinational, so there is zero added pipeline depth.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles. Expect all outputs at their reset values, including signature = 16'hFFFF. Pulse start; expect busy=1 and a_out=b_out=0 after 1 edge.
- Clean sweep: tie y_gold = y_dut. Expect done exactly 1024 edges after start and mismatch_cnt = 0, first_fail_valid = 0. signature must equal the bench MISR model; with y_dut held 0 this is SEED advanced 1024 LFSR steps. Check a_out/b_out stepping 0x00/0x00 → 0x1F/0x1F.
- Single fault: y_gold = y_dut ^ 3'b100 only for vector 10'h155 (a=0x15, b=0x0A). Expect mismatch_cnt = 1, first_fail_vec = 10'h155, first_fail_y = y_dut at that vector.
- All fail: y_gold = ~y_dut. Expect mismatch_cnt = 1024, first_fail_vec = 0.
- Control: start pulsed at cycle 300 is ignored and the sweep still finishes at 1024. abort at cycle 500 gives IDLE, busy=0, done=0, and frozen counts. A re-start then yields clean-sweep results.
- Reset mid-sweep at cycle 700: expect reset values on the next edge. A new start completes normally.
